// File: rtl/cv32e40p_tmr_fault_injector.sv
// rtl/cv32e40p_tmr_fault_injector.sv - TMR replica fault injector; optional random bit select via CV32E40P_FI_RANDOM_BIT_EN
module cv32e40p_tmr_fault_injector #(
  parameter int WIDTH   = 32,
  parameter int DELAY_W = 16,
  parameter int DUR_W   = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [WIDTH-1:0]         golden_i,
  input  logic                     cfg_valid_i,
  output logic                     cfg_ready_o,
  input  logic [1:0]               cfg_replica_i,
  input  logic [$clog2(WIDTH)-1:0] cfg_bit_i,
  input  logic [1:0]               cfg_mode_i,
  input  logic [DELAY_W-1:0]       cfg_delay_i,
  input  logic [DUR_W-1:0]         cfg_dur_i,
`ifdef CV32E40P_FI_RANDOM_BIT_EN
  input  logic                     cfg_rand_i,
`endif
  input  logic                     abort_i,
  output logic [WIDTH-1:0]         rep0_o,
  output logic [WIDTH-1:0]         rep1_o,
  output logic [WIDTH-1:0]         rep2_o,
  output logic                     active_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [15:0]              inj_count_o
);

  localparam int BIT_W = $clog2(WIDTH);

  localparam logic [1:0] MODE_FLIP = 2'b00;
  localparam logic [1:0] MODE_SA1  = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_INJECT} state_e;

  state_e             state_q, state_d;
  logic [DELAY_W-1:0] delay_cnt_q;
  logic [DUR_W-1:0]   dur_cnt_q;
  logic               perm_q;
  logic [1:0]         lat_replica_q;
  logic [BIT_W-1:0]   lat_bit_q;
  logic [1:0]         lat_mode_q;
  logic               done_q;
  logic               err_q;
  logic [15:0]        inj_cnt_q;

  logic [BIT_W-1:0]   sel_bit;
  logic               cfg_illegal;
  logic               accept;
  logic               legal_accept;
  logic               finite_end;
  logic               fault_val;

`ifdef CV32E40P_FI_RANDOM_BIT_EN
  logic [15:0] lfsr_q;

  // Free-running Fibonacci LFSR (taps 16,14,13,11) used for random bit targeting
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
`endif

  // Target bit selection and legality of the offered configuration
  always_comb begin
    sel_bit = cfg_bit_i;
`ifdef CV32E40P_FI_RANDOM_BIT_EN
    if (cfg_rand_i) sel_bit = BIT_W'(lfsr_q % 16'(WIDTH));
`endif
    cfg_illegal  = (cfg_replica_i == 2'd3) || (cfg_mode_i == 2'b11) || (32'(sel_bit) >= WIDTH);
    accept       = cfg_valid_i && cfg_ready_o;
    legal_accept = accept && !cfg_illegal;
    finite_end   = (state_q == ST_INJECT) && !perm_q && (dur_cnt_q == DUR_W'(1));
  end

  assign cfg_ready_o = (state_q == ST_IDLE) && !abort_i;
  assign active_o    = (state_q == ST_INJECT);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign inj_count_o = inj_cnt_q;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (legal_accept) state_d = (cfg_delay_i == '0) ? ST_INJECT : ST_WAIT;
      ST_WAIT:   if (delay_cnt_q == '0) state_d = ST_INJECT;
      ST_INJECT: if (finite_end) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (abort_i) state_d = ST_IDLE;
  end

  // Latched configuration, counters and status pulses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      delay_cnt_q   <= '0;
      dur_cnt_q     <= '0;
      perm_q        <= 1'b0;
      lat_replica_q <= '0;
      lat_bit_q     <= '0;
      lat_mode_q    <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      inj_cnt_q     <= '0;
    end else begin
      done_q <= finite_end && !abort_i;
      err_q  <= accept && cfg_illegal;
      if (legal_accept) begin
        lat_replica_q <= cfg_replica_i;
        lat_bit_q     <= sel_bit;
        lat_mode_q    <= cfg_mode_i;
        delay_cnt_q   <= (cfg_delay_i == '0) ? '0 : cfg_delay_i - DELAY_W'(1);
        dur_cnt_q     <= cfg_dur_i;
        perm_q        <= (cfg_dur_i == '0);
      end else if (state_q == ST_WAIT && delay_cnt_q != '0) begin
        delay_cnt_q <= delay_cnt_q - DELAY_W'(1);
      end
      // dur_cnt_q counts remaining INJECT cycles including the current one
      if (state_q == ST_INJECT && !perm_q && dur_cnt_q != '0)
        dur_cnt_q <= dur_cnt_q - DUR_W'(1);
      if (state_d == ST_INJECT && state_q != ST_INJECT && inj_cnt_q != 16'hFFFF)
        inj_cnt_q <= inj_cnt_q + 16'd1;
    end
  end

  // Zero-latency replica path; only the targeted bit of one replica is altered
  always_comb begin
    rep0_o = golden_i;
    rep1_o = golden_i;
    rep2_o = golden_i;
    if (lat_mode_q == MODE_FLIP) fault_val = ~golden_i[lat_bit_q];
    else                         fault_val = (lat_mode_q == MODE_SA1);
    if (state_q == ST_INJECT) begin
      case (lat_replica_q)
        2'd0:    rep0_o[lat_bit_q] = fault_val;
        2'd1:    rep1_o[lat_bit_q] = fault_val;
        2'd2:    rep2_o[lat_bit_q] = fault_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cv32e40p_tmr_fault_injector.sv
// tb/tb_cv32e40p_tmr_fault_injector.sv - scoreboard bench for cv32e40p_tmr_fault_injector
module tb_cv32e40p_tmr_fault_injector;

  localparam logic [31:0] G = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] golden;
  logic        valid;
  logic        ready;
  logic [1:0]  rep;
  logic [4:0]  bitx;
  logic [1:0]  mode;
  logic [15:0] dly;
  logic [7:0]  dur;
  logic        rnd;
  logic        abort;
  logic [31:0] r0, r1, r2;
  logic        active, done, err;
  logic [15:0] cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] r0, r1, r2;
    logic        a, d, e, rdy;
    logic [15:0] c;
  } exp_t;

  exp_t exp_q[$];

  cv32e40p_tmr_fault_injector #(.WIDTH(32), .DELAY_W(16), .DUR_W(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .golden_i     (golden),
    .cfg_valid_i  (valid),
    .cfg_ready_o  (ready),
    .cfg_replica_i(rep),
    .cfg_bit_i    (bitx),
    .cfg_mode_i   (mode),
    .cfg_delay_i  (dly),
    .cfg_dur_i    (dur),
`ifdef CV32E40P_FI_RANDOM_BIT_EN
    .cfg_rand_i   (rnd),
`endif
    .abort_i      (abort),
    .rep0_o       (r0),
    .rep1_o       (r1),
    .rep2_o       (r2),
    .active_o     (active),
    .done_o       (done),
    .err_o        (err),
    .inj_count_o  (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%0h required=%0h", n, f, act, req);
    end
  endtask

  // Monitor: one expectation per cycle, compared at the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "rep0", r0, e.r0);
      chk(e.name, "rep1", r1, e.r1);
      chk(e.name, "rep2", r2, e.r2);
      chk(e.name, "active", {31'd0, active}, {31'd0, e.a});
      chk(e.name, "done", {31'd0, done}, {31'd0, e.d});
      chk(e.name, "err", {31'd0, err}, {31'd0, e.e});
      chk(e.name, "ready", {31'd0, ready}, {31'd0, e.rdy});
      chk(e.name, "count", {16'd0, cnt}, {16'd0, e.c});
    end
  end

  task automatic tick(input string n, input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                      input logic ea, input logic ed, input logic ee, input logic er, input logic [15:0] ec);
    exp_q.push_back('{n, e0, e1, e2, ea, ed, ee, er, ec});
    @(posedge clk);
    #1;
    valid = 1'b0;
    abort = 1'b0;
    rnd   = 1'b0;
  endtask

  task automatic clean(input string n, input logic [31:0] g, input logic ed, input logic ee,
                       input logic er, input logic [15:0] ec);
    tick(n, g, g, g, 1'b0, ed, ee, er, ec);
  endtask

  initial begin
    rst = 1'b1; golden = G; valid = 1'b0; rep = 2'd0; bitx = 5'd0; mode = 2'd0;
    dly = 16'd0; dur = 8'd0; rnd = 1'b0; abort = 1'b0;
    @(posedge clk);
    #1;
    clean("reset", G, 0, 0, 1, 0);
    rst = 1'b0;
    clean("idle", G, 0, 0, 1, 0);

    // replica 1, bit 0 flip, delay 3, dur 2
    valid = 1; rep = 1; bitx = 0; mode = 0; dly = 3; dur = 2;
    clean("t2_accept", G, 0, 0, 1, 0);
    clean("t2_wait1", G, 0, 0, 0, 0);
    valid = 1; rep = 0; mode = 2; dly = 0; dur = 0;
    clean("t2_wait2_busy", G, 0, 0, 0, 0);
    clean("t2_wait3", G, 0, 0, 0, 0);
    tick("t2_inj1", G, 32'hA5A5A5A4, G, 1, 0, 0, 0, 1);
    tick("t2_inj2", G, 32'hA5A5A5A4, G, 1, 0, 0, 0, 1);
    clean("t2_done", G, 1, 0, 1, 1);
    clean("t2_after", G, 0, 0, 1, 1);

    // replica 2, bit 31 stuck-at-1, permanent, ended by abort
    golden = 32'h1; valid = 1; rep = 2; bitx = 31; mode = 2; dly = 0; dur = 0;
    clean("t3_accept", 32'h1, 0, 0, 1, 1);
    for (int i = 1; i <= 9; i++) begin
      if (i == 5) begin
        golden = 32'h12345678;
        tick("t3_hold_g2", 32'h12345678, 32'h12345678, 32'h92345678, 1, 0, 0, 0, 2);
      end else begin
        golden = 32'h1;
        tick("t3_hold", 32'h1, 32'h1, 32'h80000001, 1, 0, 0, 0, 2);
      end
    end
    abort = 1;
    tick("t3_abort", 32'h1, 32'h1, 32'h80000001, 1, 0, 0, 0, 2);
    clean("t3_clean", 32'h1, 0, 0, 1, 2);

    // illegal replica, then illegal mode
    golden = G; valid = 1; rep = 3; mode = 0; bitx = 0; dly = 0; dur = 1;
    clean("t4_badrep", G, 0, 0, 1, 2);
    valid = 1; rep = 0; mode = 3;
    clean("t4_err1", G, 0, 1, 1, 2);
    clean("t4_err2", G, 0, 1, 1, 2);
    clean("t4_quiet", G, 0, 0, 1, 2);

    // dur=1 fault whose only cycle coincides with abort
    valid = 1; rep = 0; bitx = 4; mode = 0; dly = 0; dur = 1;
    clean("t5_accept", G, 0, 0, 1, 2);
    abort = 1;
    tick("t5_inj_abort", 32'hA5A5A5B5, G, G, 1, 0, 0, 0, 3);
    clean("t5_nodone", G, 0, 0, 1, 3);

    // stuck-at-1 with delay 1, dur 1
    valid = 1; rep = 0; bitx = 4; mode = 2; dly = 1; dur = 1;
    clean("t5b_accept", G, 0, 0, 1, 3);
    clean("t5b_wait", G, 0, 0, 0, 3);
    tick("t5b_inj", 32'hA5A5A5B5, G, G, 1, 0, 0, 0, 4);
    clean("t5b_done", G, 1, 0, 1, 4);

    // stuck-at-0 on replica 1 bit 0
    valid = 1; rep = 1; bitx = 0; mode = 1; dly = 0; dur = 1;
    clean("t5c_accept", G, 0, 0, 1, 4);
    tick("t5c_inj", G, 32'hA5A5A5A4, G, 1, 0, 0, 0, 5);
    clean("t5c_done", G, 1, 0, 1, 5);

    // reset while waiting
    valid = 1; rep = 2; bitx = 1; mode = 0; dly = 5; dur = 3;
    clean("t6_accept", G, 0, 0, 1, 5);
    clean("t6_wait", G, 0, 0, 0, 5);
    rst = 1;
    clean("t6_rst", G, 0, 0, 1, 0);
    rst = 0;
    for (int i = 0; i < 7; i++) clean("t6_quiet", G, 0, 0, 1, 0);

`ifdef CV32E40P_FI_RANDOM_BIT_EN
    // random target right after reset: 0xACE1 mod 32 = 1
    rst = 1;
    clean("t7_rst", G, 0, 0, 1, 0);
    rst = 0;
    valid = 1; rnd = 1; rep = 0; bitx = 20; mode = 0; dly = 0; dur = 1;
    clean("t7_accept", G, 0, 0, 1, 0);
    tick("t7_inj", 32'hA5A5A5A7, G, G, 1, 0, 0, 0, 1);
    clean("t7_done", G, 1, 0, 1, 1);
`endif

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cv32e40p_tmr_fault_injector.md
Name: cv32e40p_tmr_fault_injector

Overview:
- Source-side companion to the TMR voters: takes one golden signal vector and drives three replica copies (rep0/rep1/rep2) toward the voter inputs.
- Runs one programmed fault at a time on a selected replica and bit: bit-flip, stuck-at-0 or stuck-at-1. The fault starts after a programmable delay and lasts a programmable duration.
- Used in the TFT lab harness to exercise the voter masking and faulty-flag paths; not instantiated in production builds.

Parameters:
- WIDTH, 32, width of golden and replica vectors (2..64).
- DELAY_W, 16, width of injection delay counter.
- DUR_W, 8, width of fault duration counter.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset, asynchronous, active-high.
- golden_i  input  WIDTH  fault-free source value.
- cfg_valid_i  input  1  configuration request.
- cfg_ready_o  output  1  injector can accept a configuration.
- cfg_replica_i  input  2  target replica: 0, 1, 2; 3 is illegal.
- cfg_bit_i  input  $clog2(WIDTH)  target bit index; must be < WIDTH.
- cfg_mode_i  input  2  fault mode: 00 flip, 01 stuck-at-0, 10 stuck-at-1; 11 is illegal.
- cfg_delay_i  input  DELAY_W  cycles from accept to fault start.
- cfg_dur_i  input  DUR_W  fault length in cycles; 0 means permanent.
- abort_i  input  1  cancel any pending or active fault.
- rep0_o, rep1_o, rep2_o  output  WIDTH each  replica values.
- active_o  output  1  fault currently applied.
- done_o  output  1  one-cycle pulse when a finite fault ends.
- err_o  output  1  one-cycle pulse when an illegal configuration is rejected.
- inj_count_o  output  16  number of faults started, saturating.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high (clk_i, rst_i).
- Reset values: state=IDLE, all counters 0, active_o=0, done_o=0, err_o=0, inj_count_o=0. Replicas equal golden_i immediately.
- Replica data path is combinational with zero latency. Every replica not under fault equals golden_i.
- The faulted replica applies the fault only to bit cfg_bit of golden_i, and only while active_o=1:
  - flip: bit is inverted;
  - stuck-at-0: bit forced to 0;
  - stuck-at-1: bit forced to 1.
- cfg_ready_o = (state==IDLE) && !abort_i.
- A configuration is accepted when cfg_valid_i && cfg_ready_o. Accepted fields are latched; later changes on cfg_* have no effect.
- Illegal configuration (replica=3, mode=11, or bit>=WIDTH): not latched, err_o pulses in the next cycle, state stays IDLE.
- States: IDLE, WAIT, INJECT.
- IDLE -> WAIT on a legal accept with delay>0. The delay counter loads delay-1.
- IDLE -> INJECT on a legal accept with delay=0.
  - Either way, for an accept in cycle T the fault is first visible in cycle T+1+delay.
- WAIT: decrements each cycle; moves to INJECT when the counter is 0.
- INJECT: active_o=1. On entry, inj_count_o increments, holding at 0xFFFF.
  - dur=D>0: stays exactly D cycles, then IDLE with done_o=1 in the first IDLE cycle.
  - dur=0: stays until abort_i.
- abort_i in any state: IDLE next cycle, no done_o.
- Priority: abort_i beats end-of-duration, so done_o is suppressed when both fall in the same cycle. The in-progress fault is never extended.
- Reset mid-operation: the fault is removed asynchronously and every register goes to its reset value.
- done_o and err_o never pulse in the same cycle.

Optional Feature:
- Macro: CV32E40P_FI_RANDOM_BIT_EN.
- When defined:
  - adds input cfg_rand_i (1 bit);
  - adds a 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 0xACE1 at reset, advancing every cycle.
  - On a legal accept with cfg_rand_i=1, the target bit is (LFSR value at accept) mod WIDTH and cfg_bit_i is ignored, including for the legality check.
- When undefined: the port and the LFSR are absent, and the bit always comes from cfg_bit_i.

Test Plan:
- Reset, golden_i=0xA5A5A5A5, no config -> all reps 0xA5A5A5A5, cfg_ready_o=1, inj_count_o=0.
- Config replica=1, bit=0, flip, delay=3, dur=2, golden_i=0xA5A5A5A5 -> rep1_o=0xA5A5A5A4 in cycles T+4..T+5 only; done_o at T+6; inj_count_o=1; rep0/rep2 unchanged.
- Config replica=2, bit=31, stuck-at-1, delay=0, dur=0, golden_i=0x00000001 -> from T+1 rep2_o=0x80000001 indefinitely; abort_i at T+10 -> clean at T+11, no done_o.
- Config replica=3, or mode=11 -> err_o pulse at T+1, state stays IDLE, no active_o, inj_count_o unchanged.
- abort_i asserted together with the end of a dur=1 fault -> IDLE, done_o=0. Separately, rst_i asserted mid-WAIT -> outputs clean immediately, inj_count_o=0.
- With CV32E40P_FI_RANDOM_BIT_EN: reset, accept at cycle 0, cfg_rand_i=1, WIDTH=32 -> faulted bit = (0xACE1 mod 32) = 1.
